// File: rtl/if_id_skid_reg.sv
// IF/ID boundary register with a one-entry skid buffer: every output comes from a flop,
// so there is no combinational ready path from decode back to fetch, and throughput is still one instruction per cycle.
module if_id_skid_reg #(
  parameter int          INSTR_W  = 16,
  parameter int          PC_W     = 16,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [1:0]         occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               accept, drain;
  logic               load_main_in, load_main_skid, load_skid;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] nop_word;

  assign nop_word = INSTR_W'(NOP_WORD);
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (drain) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a drain can move the state.
          if (drain) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Control and main-entry outputs; all derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      occupancy <= 2'd0;
      out_instr <= nop_word;
      out_pc    <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != EMPTY);
      in_ready  <= (state_nxt != FULL);
      occupancy <= state_nxt;
      if (load_main_in) begin
        out_instr <= in_instr;
        out_pc    <= in_pc;
      end else if (load_main_skid) begin
        out_instr <= skid_instr;
        out_pc    <= skid_pc;
      end else if (state_nxt == EMPTY) begin
        out_instr <= nop_word;
      end
    end
  end

  // Skid entry: data only, its validity is tracked by the state.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_instr <= in_instr;
      skid_pc    <= in_pc;
    end
  end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: a FIFO-queue model of the held entries is checked every cycle,
// and directed scenarios also carry hand-computed literal expectations.
module tb_if_id_skid_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [15:0] in_instr, in_pc, out_instr, out_pc;
  logic [1:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] qi[$];
  logic [15:0] qp[$];
  bit          model_on   = 1'b0;
  bit          chk_stable = 1'b0;
  logic [15:0] prev_instr, prev_pc;

  if_id_skid_reg #(.INSTR_W(16), .PC_W(16), .NOP_WORD(16'h0000)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a 2-deep FIFO whose head is on out_*.
  always @(posedge clk) begin
    bit dr, ac;
    chk_stable = 1'b0;
    if (rst) begin
      qi.delete(); qp.delete();
      model_on = 1'b1;
    end else if (flush) begin
      qi.delete(); qp.delete();
    end else begin
      dr = (qi.size() > 0) && out_ready;
      ac = in_valid && (qi.size() < 2);
      chk_stable = (qi.size() > 0) && !out_ready;
      if (dr) begin
        void'(qi.pop_front());
        void'(qp.pop_front());
      end
      if (ac) begin
        qi.push_back(in_instr);
        qp.push_back(in_pc);
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("m_out_valid", 32'(out_valid), 32'(qi.size() > 0));
      check("m_in_ready", 32'(in_ready), 32'(qi.size() < 2));
      check("m_occupancy", 32'(occupancy), 32'(qi.size()));
      check("m_out_instr", 32'(out_instr), (qi.size() > 0) ? 32'(qi[0]) : 32'h0);
      if (qi.size() > 0) check("m_out_pc", 32'(out_pc), 32'(qp[0]));
      if (chk_stable) begin
        check("stable_instr", 32'(out_instr), 32'(prev_instr));
        check("stable_pc", 32'(out_pc), 32'(prev_pc));
      end
      prev_instr = out_instr;
      prev_pc    = out_pc;
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc, input logic rdy);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
  endtask

  task automatic expect_state(input string tag, input logic v, input logic [15:0] ins,
                              input logic rdy, input logic [1:0] occ);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_instr"}, 32'(out_instr), 32'(ins));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(rdy));
    check({tag, "_occ"}, 32'(occupancy), 32'(occ));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    tick; tick;
    expect_state("reset", 1'b0, 16'h0000, 1'b1, 2'd0);
    check("reset_pc", 32'(out_pc), 32'h0);
    rst = 1'b0;

    // Full-rate stream
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'h1001 + 16'(i), 16'(2 * i), 1'b1);
      tick;
      expect_state("stream", 1'b1, 16'h1001 + 16'(i), 1'b1, 2'd1);
      check("stream_pc", 32'(out_pc), 32'(2 * i));
    end
    drive(1'b0, 16'h0, 16'h0, 1'b1);
    tick;
    expect_state("stream_end", 1'b0, 16'h0000, 1'b1, 2'd0);

    // Backpressure into the skid entry
    drive(1'b1, 16'h2001, 16'h20, 1'b1); tick;
    expect_state("bp1", 1'b1, 16'h2001, 1'b1, 2'd1);
    drive(1'b1, 16'h2002, 16'h22, 1'b0); tick;
    expect_state("bp2", 1'b1, 16'h2001, 1'b0, 2'd2);
    drive(1'b1, 16'h2003, 16'h24, 1'b0); tick;
    expect_state("bp3", 1'b1, 16'h2001, 1'b0, 2'd2);
    drive(1'b1, 16'h2003, 16'h24, 1'b1); tick;
    expect_state("bp4", 1'b1, 16'h2002, 1'b1, 2'd1);
    tick;
    expect_state("bp5", 1'b1, 16'h2003, 1'b1, 2'd1);
    drive(1'b0, 16'h0, 16'h0, 1'b1); tick;
    expect_state("bp6", 1'b0, 16'h0000, 1'b1, 2'd0);

    // Flush while full
    drive(1'b1, 16'h6001, 16'h60, 1'b0); tick;
    drive(1'b1, 16'h6002, 16'h62, 1'b0); tick;
    expect_state("pre_flush", 1'b1, 16'h6001, 1'b0, 2'd2);
    flush = 1'b1;
    drive(1'b1, 16'h3333, 16'h33, 1'b0); tick;
    flush = 1'b0;
    expect_state("flush", 1'b0, 16'h0000, 1'b1, 2'd0);
    drive(1'b0, 16'h0, 16'h0, 1'b1); tick;
    expect_state("post_flush", 1'b0, 16'h0000, 1'b1, 2'd0);

    // Simultaneous accept and drain
    drive(1'b1, 16'h4001, 16'h40, 1'b0); tick;
    expect_state("ad1", 1'b1, 16'h4001, 1'b1, 2'd1);
    drive(1'b1, 16'h4002, 16'h42, 1'b1); tick;
    expect_state("ad2", 1'b1, 16'h4002, 1'b1, 2'd1);
    drive(1'b0, 16'h0, 16'h0, 1'b1); tick;

    // Reset while full
    drive(1'b1, 16'h7001, 16'h70, 1'b0); tick;
    drive(1'b1, 16'h7002, 16'h72, 1'b0); tick;
    expect_state("pre_rst", 1'b1, 16'h7001, 1'b0, 2'd2);
    rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0); tick;
    rst = 1'b0;
    expect_state("mid_rst", 1'b0, 16'h0000, 1'b1, 2'd0);
    check("mid_rst_pc", 32'(out_pc), 32'h0);
    drive(1'b1, 16'h5005, 16'h50, 1'b1); tick;
    expect_state("post_rst", 1'b1, 16'h5005, 1'b1, 2'd1);
    check("post_rst_pc", 32'(out_pc), 32'h50);
    drive(1'b0, 16'h0, 16'h0, 1'b1); tick;

    // Random valid/ready traffic, checked by the model every cycle
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 16'(i * 2), 1'($urandom_range(0, 3) != 0 ? 1 : 0));
      if (i % 500 < 100) out_ready = 1'($urandom_range(0, 3) == 0 ? 1 : 0);
      tick;
    end
    drive(1'b0, 16'h0, 16'h0, 1'b1);
    tick; tick; tick;
    expect_state("final", 1'b0, 16'h0000, 1'b1, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
